lsu_bus: RTL
============

Name: lsu_bus

Overview:
- Parametrised load/store unit for the next core revision.
- Replaces the combinational mem_addr/mem_wdata/mem_we path with a valid/ready request to the core and a req/ack handshake to a word-wide memory bus that may stall.
- Generates byte enables, handles lane shift and sign/zero extension, and detects misaligned or illegal accesses.
- Returns a bus timeout error instead of hanging the core.

Parameters:
- XLEN, 32, data width and bus word width; legal values 32 or 64.
- ADDR_W, 32, address width.
- TIMEOUT, 255, maximum BUS-state cycles without bus_ack_i before an error response; must be at least 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  core requests an access; held stable until resp_valid_o.
- req_ready_o  out  1  unit can accept a request (IDLE only).
- req_we_i  in  1  1 = store, 0 = load.
- funct3_i  in  3  RISC-V size/sign code (000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU).
- addr_i  in  ADDR_W  byte address.
- wdata_i  in  XLEN  store data, right-aligned.
- resp_valid_o  out  1  one-cycle response strobe.
- rdata_o  out  XLEN  extended load data; 0 for stores and errors.
- err_o  out  1  qualifies resp_valid_o: misaligned, illegal size, or timeout.
- stall_o  out  1  core must hold its PC and IR.
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  bus write.
- bus_addr_o  out  ADDR_W  word-aligned address (low log2(XLEN/8) bits zero).
- bus_be_o  out  XLEN/8  byte enables.
- bus_wdata_o  out  XLEN  lane-shifted write data.
- bus_ack_i  in  1  bus completes the access this cycle.
- bus_rdata_i  in  XLEN  read word, valid with bus_ack_i.

Behaviour:
- Reset: state IDLE. All outputs 0 except req_ready_o = 1. Timeout counter 0; captured request registers 0.
- States: IDLE, BUS, RESP.
- IDLE:
  - req_ready_o = 1. Accept when req_valid_i = 1; capture we, funct3, addr, wdata.
  - Illegal request (see checks) -> RESP with err. Otherwise -> BUS.
- Illegal-request checks:
  - Misaligned: H/HU with addr[0] = 1; W/WU with addr[1:0] != 0; D with addr[2:0] != 0.
  - Illegal size: funct3 111; 011 or 110 when XLEN = 32; a store with funct3[2] = 1.
  - An illegal request never asserts bus_req_o.
- BUS:
  - bus_req_o = 1 and all bus_* outputs stable until bus_ack_i.
  - bus_ack_i = 1 -> capture extended read data -> RESP, err = 0.
  - Counter increments each BUS cycle without ack; when it reaches TIMEOUT -> RESP, err = 1, bus_req_o deasserts.
  - Ack in the same cycle the counter hits TIMEOUT: the ack wins (success).
- RESP:
  - resp_valid_o = 1 for exactly one cycle; rdata_o and err_o valid in that cycle.
  - -> IDLE with counter cleared.
  - No new request is accepted in RESP; the earliest next accept is the following cycle.
- stall_o = (IDLE and req_valid_i) or BUS. It is combinational and is 0 in RESP, so the core retires in the RESP cycle.
- Latency:
  - Zero-wait bus (ack in the first BUS cycle): resp_valid_o 2 cycles after accept.
  - Each wait cycle adds 1.
  - Error on accept: resp_valid_o 1 cycle after accept.
- Lane logic, with off = addr[log2(XLEN/8)-1:0]:
  - bus_be_o = size mask (B = 1, H = 3, W = 0xF, D = 0xFF) shifted left by off.
  - bus_wdata_o = wdata_i shifted left by 8*off.
  - Load: shift bus_rdata_i right by 8*off, then truncate to the access size. Sign-extend for B/H/W (W only when XLEN = 64); zero-extend for BU/HU/WU. D is passed unchanged.
- bus_ack_i outside BUS is ignored.
- bus_rdata_i is sampled only on the ack cycle.
- rdata_o holds its value outside RESP; only the resp_valid_o cycle is meaningful.
- Reset asserted mid-access: all outputs return to reset values immediately (asynchronously). The pending response is discarded.

Test Plan:
- XLEN = 32, load LH addr 0x1002, bus returns 0x8001_0000 with ack in the first BUS cycle -> bus_addr_o 0x1000, bus_be_o 0b1100, resp_valid_o 2 cycles after accept, rdata_o 0xFFFF_8001, err_o 0.
- XLEN = 32, store SB addr 0x2003, wdata 0x0000_00A5, ack after 3 wait cycles -> bus_we_o 1, bus_be_o 0b1000, bus_wdata_o[31:24] = 0xA5, stall_o high 4 cycles after accept, resp_valid_o on the following cycle with rdata_o 0.
- Load LW addr 0x0006 -> no bus_req_o; resp_valid_o 1 cycle after accept with err_o 1. Likewise funct3 011 at XLEN = 32, and SBU (store, funct3 100) -> err_o 1.
- TIMEOUT = 4, load with bus_ack_i held 0 -> bus_req_o high exactly 4 cycles, then resp_valid_o with err_o 1. Repeat with ack on the 4th BUS cycle -> err_o 0.
- XLEN = 64, LWU addr 0x0C, bus word 0xFEDC_BA98_7654_3210 -> bus_be_o 0xF0, rdata_o 0x0000_0000_FEDC_BA98. LW on the same word -> 0xFFFF_FFFF_FEDC_BA98.
- Assert rst in BUS with bus_req_o high -> bus_req_o and stall_o drop in the same cycle, req_ready_o = 1, no resp_valid_o. A request after reset release completes normally.

Source files
------------

// File: rtl/lsu_bus.sv
// Load/store unit: core valid/ready request in, word-wide req/ack bus out.
// Handles byte lanes, load extension, alignment/size checks and bus timeout.
module lsu_bus #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [2:0]          funct3_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [XLEN-1:0]     wdata_i,
  output logic                resp_valid_o,
  output logic [XLEN-1:0]     rdata_o,
  output logic                err_o,
  output logic                stall_o,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [XLEN/8-1:0]   bus_be_o,
  output logic [XLEN-1:0]     bus_wdata_o,
  input  logic                bus_ack_i,
  input  logic [XLEN-1:0]     bus_rdata_i
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        r_state;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_rdata;
  logic              r_err;

  logic              w_misalign;
  logic              w_bad_size;
  logic              w_illegal;
  logic [OFFW-1:0]   w_off;
  logic [OFFW+2:0]   w_sh_bits;
  logic [7:0]        w_mask8;
  logic [NB-1:0]     w_be;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_rsh;
  logic [XLEN-1:0]   w_load;
  logic              w_sign;
  int                w_bits;
  logic              w_in_bus;

  always_comb begin
    w_misalign = 1'b0;
    case (funct3_i[1:0])
      2'd1:    w_misalign = addr_i[0];
      2'd2:    w_misalign = |addr_i[1:0];
      2'd3:    w_misalign = |addr_i[2:0];
      default: w_misalign = 1'b0;
    endcase
    // D and WU only exist on a 64-bit datapath; stores have no unsigned forms.
    w_bad_size = (funct3_i == 3'b111) || (req_we_i && funct3_i[2]) ||
                 ((XLEN == 32) && (funct3_i == 3'b011 || funct3_i == 3'b110));
    w_illegal  = w_misalign || w_bad_size;
  end

  assign w_off     = r_addr[OFFW-1:0];
  assign w_sh_bits = {w_off, 3'b000};

  always_comb begin
    case (r_funct3[1:0])
      2'd0:    w_mask8 = 8'h01;
      2'd1:    w_mask8 = 8'h03;
      2'd2:    w_mask8 = 8'h0F;
      default: w_mask8 = 8'hFF;
    endcase
  end

  assign w_be    = w_mask8[NB-1:0] << w_off;
  assign w_wdata = r_wdata << w_sh_bits;
  assign w_rsh   = bus_rdata_i >> w_sh_bits;

  always_comb begin
    w_bits = XLEN;
    w_sign = 1'b0;
    case (r_funct3[1:0])
      2'd0:    begin w_bits = 8;  w_sign = w_rsh[7];  end
      2'd1:    begin w_bits = 16; w_sign = w_rsh[15]; end
      2'd2:    begin w_bits = 32; w_sign = w_rsh[31]; end
      default: begin w_bits = XLEN; w_sign = 1'b0; end
    endcase
    if (r_funct3[2]) w_sign = 1'b0;
    w_load = w_rsh;
    for (int i = 0; i < XLEN; i++) begin
      if (i >= w_bits) w_load[i] = w_sign;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (req_valid_i) begin
            r_we     <= req_we_i;
            r_funct3 <= funct3_i;
            r_addr   <= addr_i;
            r_wdata  <= wdata_i;
            if (w_illegal) begin
              r_err   <= 1'b1;
              r_rdata <= '0;
              r_state <= S_RESP;
            end else begin
              r_err   <= 1'b0;
              r_state <= S_BUS;
            end
          end
        end
        S_BUS: begin
          // An ack on the final allowed cycle takes priority over the timeout.
          if (bus_ack_i) begin
            r_rdata <= r_we ? '0 : w_load;
            r_err   <= 1'b0;
            r_state <= S_RESP;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_cnt   <= r_cnt + 1'b1;
            r_state <= S_RESP;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_in_bus     = (r_state == S_BUS);
  assign req_ready_o  = (r_state == S_IDLE);
  assign resp_valid_o = (r_state == S_RESP);
  assign err_o        = (r_state == S_RESP) && r_err;
  assign rdata_o      = r_rdata;
  // Gated by rst so the stall drops the instant reset is applied.
  assign stall_o      = !rst && (((r_state == S_IDLE) && req_valid_i) || w_in_bus);
  assign bus_req_o    = w_in_bus;
  assign bus_we_o     = w_in_bus && r_we;
  assign bus_addr_o   = w_in_bus ? {r_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}} : '0;
  assign bus_be_o     = w_in_bus ? w_be : '0;
  assign bus_wdata_o  = w_in_bus ? w_wdata : '0;

endmodule
